frogger_matrix_scan: RTL
========================

# frogger_matrix_scan

Display-side reader for the frogger game core: snapshots the eight 8-bit lane rows and the frog position once per frame and multiplexes them onto an 8x8 LED matrix, one row at a time. It sits between the game core and the board pins and adds frog blinking, inter-row blanking and frame-level collision reporting. It is tear-free: the core may update lanes on any cycle, and only frame-boundary snapshots are displayed.

## Interface
- SCAN_DIV, 1024: clocks per row period; legal range ≥ 2.
- BLANK_CYCLES, 2: leading blanked clocks of each row period; legal range 0 ≤ BLANK_CYCLES < SCAN_DIV.
- BLINK_FRAMES, 16: frames per frog blink half-period; legal range ≥ 1.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- lanes  in  64  lane r occupies lanes[8r+7:8r]; bit c is column c, 1 = car.
- frog_row  in  3  frog vertical position (0 = top/win row).
- frog_col  in  3  frog horizontal position.
- row_n  out  8  active-low one-hot row drive.
- col  out  8  active-high column drive.
- frame_start  out  1  one-cycle pulse on the snapshot cycle.
- collision  out  1  frog overlaps a car in the current snapshot.

## Operation
- State:
  - row_idx (3 b), cnt (clog2(SCAN_DIV) b), shadow (64 b), frog_r_s and frog_c_s (3 b each), blink (1 b), frame_cnt (clog2(BLINK_FRAMES) b).
- cnt counts 0..SCAN_DIV-1. At SCAN_DIV-1, cnt wraps to 0 and row_idx increments; 7 wraps to 0.
- Snapshot:
  - Occurs on the edge where cnt == SCAN_DIV-1 and row_idx == 7.
  - On that edge: shadow <= lanes, frog_r_s <= frog_row, frog_c_s <= frog_col.
  - frame_start is high for the one cycle following that edge, i.e. the first cycle of row 0.
- Blink:
  - frame_cnt increments on each snapshot.
  - On the snapshot where frame_cnt == BLINK_FRAMES-1, frame_cnt clears to 0 and blink toggles on the same edge.
- Pixel data for row r = shadow[8r+7:8r], with bit frog_c_s forced to 1 when r == frog_r_s and blink == 1. Frog is ORed over cars.
- Blanking:
  - While cnt < BLANK_CYCLES: row_n = 8'hFF, col = 0.
  - Otherwise: row_n = ~(1 << row_idx), col = pixel data.
- row_n and col are registers. They carry the decode of the row_idx/cnt values held in the same cycle, computed from next state, so there is no extra pipeline stage.
- Inputs are ignored on all cycles other than the snapshot edge.

## Timing
- Reset values:
  - row_idx = 0, cnt = 0, shadow = 0, frog_r_s = 0, frog_c_s = 0, blink = 1, frame_cnt = 0.
  - row_n = 8'hFF, col = 0, frame_start = 0, collision = 0.
- Reset is asynchronous. Asserting it mid-row forces all outputs to their reset values immediately. The first snapshot occurs 8·SCAN_DIV clocks after deassertion.
- Frame period = 8·SCAN_DIV clocks. Row r is lit for SCAN_DIV−BLANK_CYCLES clocks.
- Input-to-display latency: a lanes value present at the snapshot edge appears on col starting in the first unblanked cycle of row 0.
- Simultaneous snapshot and blink toggle on one edge: the new blink value applies to the new frame.

## Configuration
- FROGGER_SCAN_COLLIDE_EN defined:
  - On the snapshot edge, collision <= lanes[8·frog_row + frog_col], evaluated from the inputs.
  - collision is high during the same cycle as frame_start and holds for the whole frame.
- Undefined: collision is tied to 0 and no collision logic is synthesised.

## Test plan
All runs use SCAN_DIV=4, BLANK_CYCLES=1, BLINK_FRAMES=2.
- Reset release, all lanes 0, frog (7,3):
  - first frame displays nothing except blink-lit frog data from the reset shadow, i.e. row 0 col 8'h01;
  - frame_start first pulses 32 clocks after deassertion;
  - after it, row 7 shows col 8'h08.
- lanes row1 = 8'hEE, other rows 0, frog (7,0):
  - during row 1 the bench sees 1 cycle of row_n=FF/col=00, then 3 cycles of row_n=8'hFD/col=8'hEE.
- Change lanes mid-frame (row 3): displayed data is unchanged until the next frame_start.
- Blink: frog (4,5), lanes 0:
  - row 4 col = 8'h20 for 2 frames, then 8'h00 for 2 frames, then the pattern repeats;
  - blink is reset-high.
- With the macro defined, row 5 = 8'h99 and frog (5,0): collision = 1 from the frame_start cycle. Moving the frog to (5,1) clears collision at the next snapshot. Without the macro, collision stays 0.
- Assert reset during row 6 cnt 2: row_n = 8'hFF and col = 0 in the same cycle, before any clock edge.

Source files
------------

// File: rtl/frogger_matrix_scan.sv
// frogger_matrix_scan
// -------------------
// Display-side reader for the frogger game core. Once per frame it snapshots
// the eight 8-bit lane rows and the frog position. It then multiplexes the
// snapshot onto an 8x8 LED matrix, one row per SCAN_DIV clocks. Each row
// period starts with BLANK_CYCLES blanked clocks. The frog pixel blinks with
// a half-period of BLINK_FRAMES frames. Because only the frame-boundary
// snapshot is ever displayed, the core may update its lanes on any cycle
// without tearing.
//
// Optional feature (compile-time macro FROGGER_SCAN_COLLIDE_EN):
//   defined   - collision is registered on the snapshot edge from the live
//               inputs and held for the whole frame.
//   undefined - collision is tied low and no collision logic exists.
//
// Parameters:
//   SCAN_DIV      clocks per row period (>= 2)
//   BLANK_CYCLES  leading blanked clocks per row period (0 .. SCAN_DIV-1)
//   BLINK_FRAMES  frames per frog blink half-period (>= 1)
//
// Ports:
//   clk          in   1   system clock
//   reset        in   1   asynchronous, active-high reset
//   lanes        in  64   lane r at lanes[8r+7:8r], bit c = column c, 1 = car
//   frog_row     in   3   frog row (0 = top/win row)
//   frog_col     in   3   frog column
//   row_n        out  8   active-low one-hot row drive (registered)
//   col          out  8   active-high column drive (registered)
//   frame_start  out  1   one-cycle pulse in the first cycle of row 0
//   collision    out  1   frog overlaps a car in the current snapshot
module frogger_matrix_scan #(
  parameter int SCAN_DIV     = 1024,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_FRAMES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] lanes,
  input  logic [2:0]  frog_row,
  input  logic [2:0]  frog_col,
  output logic [7:0]  row_n,
  output logic [7:0]  col,
  output logic        frame_start,
  output logic        collision
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FC_MAX  = FW'(BLINK_FRAMES - 1);

  // Scan state
  logic [2:0]    r_row_idx;
  logic [CW-1:0] r_cnt;
  logic [63:0]   r_shadow;
  logic [2:0]    r_frog_r_s;
  logic [2:0]    r_frog_c_s;
  logic          r_blink;
  logic [FW-1:0] r_frame_cnt;

  // Output registers
  logic [7:0]    r_row_n;
  logic [7:0]    r_col;
  logic          r_frame_start;

  // Next-state wires
  logic          w_cnt_wrap;
  logic          w_snap;
  logic          w_fc_last;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    w_row_nxt;
  logic [63:0]   w_shadow_nxt;
  logic [2:0]    w_frog_r_nxt;
  logic [2:0]    w_frog_c_nxt;
  logic          w_blink_nxt;
  logic [FW-1:0] w_frame_cnt_nxt;
  logic          w_blank_nxt;
  logic [7:0]    w_frog_mask;
  logic [7:0]    w_pix_nxt;
  logic [7:0]    w_row_n_nxt;
  logic [7:0]    w_col_nxt;

  assign w_cnt_wrap = (r_cnt == CNT_MAX);
  // The snapshot edge is the last clock of row 7, so the new frame starts in row 0.
  assign w_snap     = w_cnt_wrap && (r_row_idx == 3'd7);
  assign w_fc_last  = (r_frame_cnt == FC_MAX);

  assign w_cnt_nxt    = w_cnt_wrap ? {CW{1'b0}} : (r_cnt + CW'(1));
  assign w_row_nxt    = w_cnt_wrap ? (r_row_idx + 3'd1) : r_row_idx;
  assign w_shadow_nxt = w_snap ? lanes    : r_shadow;
  assign w_frog_r_nxt = w_snap ? frog_row : r_frog_r_s;
  assign w_frog_c_nxt = w_snap ? frog_col : r_frog_c_s;

  // The blink toggle coincides with a snapshot, so the new phase covers the whole new frame.
  assign w_frame_cnt_nxt = !w_snap   ? r_frame_cnt :
                           w_fc_last ? {FW{1'b0}}  : (r_frame_cnt + FW'(1));
  assign w_blink_nxt     = (w_snap && w_fc_last) ? ~r_blink : r_blink;

  // The outputs are decoded from next state so they line up with row_idx/cnt without an extra stage.
  assign w_blank_nxt = (int'(w_cnt_nxt) < BLANK_CYCLES);
  assign w_frog_mask = ((w_row_nxt == w_frog_r_nxt) && w_blink_nxt) ?
                       (8'h01 << w_frog_c_nxt) : 8'h00;
  assign w_pix_nxt   = w_shadow_nxt[{w_row_nxt, 3'b000} +: 8] | w_frog_mask;
  assign w_row_n_nxt = w_blank_nxt ? 8'hFF : ~(8'h01 << w_row_nxt);
  assign w_col_nxt   = w_blank_nxt ? 8'h00 : w_pix_nxt;

  // Scan counters, frame snapshot and blink phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row_idx   <= 3'd0;
      r_cnt       <= {CW{1'b0}};
      r_shadow    <= 64'd0;
      r_frog_r_s  <= 3'd0;
      r_frog_c_s  <= 3'd0;
      r_blink     <= 1'b1;
      r_frame_cnt <= {FW{1'b0}};
    end else begin
      r_row_idx   <= w_row_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shadow    <= w_shadow_nxt;
      r_frog_r_s  <= w_frog_r_nxt;
      r_frog_c_s  <= w_frog_c_nxt;
      r_blink     <= w_blink_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
    end
  end

  // Registered matrix drive and frame marker
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row_n       <= 8'hFF;
      r_col         <= 8'h00;
      r_frame_start <= 1'b0;
    end else begin
      r_row_n       <= w_row_n_nxt;
      r_col         <= w_col_nxt;
      r_frame_start <= w_snap;
    end
  end

  assign row_n       = r_row_n;
  assign col         = r_col;
  assign frame_start = r_frame_start;

`ifdef FROGGER_SCAN_COLLIDE_EN
  logic r_collision;

  // Frame-level collision, taken from the live inputs on the snapshot edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_collision <= 1'b0;
    end else if (w_snap) begin
      r_collision <= lanes[{frog_row, frog_col}];
    end else begin
      r_collision <= r_collision;
    end
  end

  assign collision = r_collision;
`else
  assign collision = 1'b0;
`endif

endmodule
